// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
//   arb_state_t : ownership FSM encoding (IDLE / OWN)
//   weight_at() : extracts one per-port weight field from a packed vector
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Upper bounds used by weight_at(); callers zero-extend into these widths.
  localparam int MAX_VEC_W   = 256;
  localparam int MAX_FIELD_W = 16;

  // Returns field p (w bits wide, packed at p*w) of vec, zero-extended.
  function automatic logic [MAX_FIELD_W-1:0] weight_at(
    input logic [MAX_VEC_W-1:0] vec,
    input int unsigned          p,
    input int unsigned          w
  );
    logic [MAX_FIELD_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < MAX_FIELD_W; i++) begin
      if (i < w) res[i] = vec[p * w + i];
    end
    return res;
  endfunction

endpackage

// File: rtl/weighted_rr_arbiter_search.sv
// Combinational rotating-priority search.
//   req_i    : request vector
//   pivot_i  : index with highest priority this cycle
//   winner_o : first requesting index at or above pivot_i, wrapping
//   found_o  : at least one request is asserted
module rr_pivot_search #(
  parameter int PORTS = 4,
  parameter int IDX_W = 2
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [IDX_W-1:0] pivot_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             found_o
);

  int c;

  // Walk from the farthest candidate back to the pivot so the nearest
  // requester is the last one written and therefore wins.
  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    c        = 0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      c = (int'(pivot_i) + k) % PORTS;
      if (req_i[c]) begin
        winner_o = IDX_W'(c);
        found_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter. A grantee keeps ownership for up to
// max(weight,1) acknowledged beats or until it drops its request; priority
// then rotates to the port after the released owner.
// Ports:
//   i_clk, i_rstn  : clock, asynchronous active-low reset
//   i_req_vec      : level request per port
//   i_weight       : per-port beat budget, port p at [p*WEIGHT_W +: WEIGHT_W]
//   i_ack          : sink consumed one beat from the current grantee
//   o_grant_vec    : one-hot grant or zero
//   o_grant_idx    : grantee index, 0 when idle
//   o_grant_valid  : any grant
// Handshake: a beat transfers in a cycle where o_grant_valid and i_ack are
// both high; i_ack is ignored otherwise.
module weighted_rr_arbiter
  import arb_pkg::*;
#(
  parameter int PORTS      = 4,
  parameter int WEIGHT_W   = 4,
  parameter bit ZERO_CYCLE = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic [PORTS-1:0]          i_req_vec,
  input  logic [PORTS*WEIGHT_W-1:0] i_weight,
  input  logic                      i_ack,
  output logic [PORTS-1:0]          o_grant_vec,
  output logic [$clog2(PORTS)-1:0]  o_grant_idx,
  output logic                      o_grant_valid
);

  localparam int IDX_W = $clog2(PORTS);

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [WEIGHT_W-1:0]   credit_q, credit_d;
  logic [IDX_W-1:0]      last_q, last_d;

  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_valid;
  logic                  own_req;
  logic [IDX_W-1:0]      pivot;
  logic [IDX_W-1:0]      winner;
  logic                  found;
  logic [MAX_VEC_W-1:0]  weight_ext;
  logic [MAX_FIELD_W-1:0] win_field;
  logic [MAX_FIELD_W-1:0] win_budget;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] x);
    return (32'(x) == PORTS - 1) ? '0 : x + 1'b1;
  endfunction

  assign own_req = (state_q == OWN) && i_req_vec[owner_q];

  // While owning, the only search that matters is the one after this owner
  // releases, so the pivot follows the owner; in IDLE it follows last_q.
  assign pivot = next_idx((state_q == OWN) ? owner_q : last_q);

  rr_pivot_search #(
    .PORTS (PORTS),
    .IDX_W (IDX_W)
  ) u_search (
    .req_i    (i_req_vec),
    .pivot_i  (pivot),
    .winner_o (winner),
    .found_o  (found)
  );

  assign weight_ext = MAX_VEC_W'(i_weight);
  assign win_field  = weight_at(weight_ext, 32'(winner), WEIGHT_W);
  assign win_budget = (win_field == '0) ? MAX_FIELD_W'(1) : win_field;

  generate
    if (ZERO_CYCLE) begin : g_zero_cycle
      // A freshly found winner is visible this cycle, so a same-cycle ack
      // already counts against its budget.
      always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        credit_d    = credit_q;
        last_d      = last_q;
        grant_idx   = '0;
        grant_valid = 1'b0;
        if (own_req) begin
          grant_valid = 1'b1;
          grant_idx   = owner_q;
          if (i_ack) begin
            if (credit_q == WEIGHT_W'(1)) begin
              state_d = IDLE;
              last_d  = owner_q;
            end else begin
              credit_d = credit_q - WEIGHT_W'(1);
            end
          end
        end else begin
          if (state_q == OWN) last_d = owner_q;
          state_d = IDLE;
          if (found) begin
            grant_valid = 1'b1;
            grant_idx   = winner;
            if (i_ack && (win_budget == MAX_FIELD_W'(1))) begin
              last_d = winner;  // acquired and fully spent in one cycle
            end else begin
              state_d  = OWN;
              owner_d  = winner;
              credit_d = i_ack ? WEIGHT_W'(win_budget - MAX_FIELD_W'(1))
                               : WEIGHT_W'(win_budget);
            end
          end
        end
      end
    end else begin : g_registered
      // Winners are only registered; the search also runs on the last acked
      // beat so the next owner is visible in the following cycle.
      always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        credit_d    = credit_q;
        last_d      = last_q;
        grant_idx   = '0;
        grant_valid = 1'b0;
        if (own_req) begin
          grant_valid = 1'b1;
          grant_idx   = owner_q;
          if (i_ack) begin
            if (credit_q == WEIGHT_W'(1)) begin
              state_d = IDLE;
              last_d  = owner_q;
              if (found) begin
                state_d  = OWN;
                owner_d  = winner;
                credit_d = WEIGHT_W'(win_budget);
              end
            end else begin
              credit_d = credit_q - WEIGHT_W'(1);
            end
          end
        end else begin
          if (state_q == OWN) last_d = owner_q;
          state_d = IDLE;
          if (found) begin
            state_d  = OWN;
            owner_d  = winner;
            credit_d = WEIGHT_W'(win_budget);
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      credit_q <= '0;
      last_q   <= IDX_W'(PORTS - 1);
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
      last_q   <= last_d;
    end
  end

  // Reset masks the outputs combinationally so a zero-cycle search cannot
  // leak a grant while i_rstn is low.
  assign o_grant_valid = i_rstn && grant_valid;
  assign o_grant_idx   = o_grant_valid ? grant_idx : '0;
  assign o_grant_vec   = o_grant_valid ? (PORTS'(1) << grant_idx) : '0;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
module tb_weighted_rr_arbiter;

  logic        i_clk;
  logic        i_rstn;
  logic [3:0]  i_req_vec;
  logic [15:0] i_weight;
  logic        i_ack;
  logic [3:0]  g1_vec, g0_vec;
  logic [1:0]  g1_idx, g0_idx;
  logic        g1_valid, g0_valid;

  int checks = 0;
  int errors = 0;

  // reference model state, index 0 = registered mode, 1 = zero-cycle mode
  int m_own[2];
  int m_left[2];
  int m_last[2];
  int wait_beats[2][4];

  weighted_rr_arbiter #(.PORTS(4), .WEIGHT_W(4), .ZERO_CYCLE(1'b1)) u_z1 (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_req_vec(i_req_vec), .i_weight(i_weight),
    .i_ack(i_ack), .o_grant_vec(g1_vec), .o_grant_idx(g1_idx), .o_grant_valid(g1_valid)
  );

  weighted_rr_arbiter #(.PORTS(4), .WEIGHT_W(4), .ZERO_CYCLE(1'b0)) u_z0 (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_req_vec(i_req_vec), .i_weight(i_weight),
    .i_ack(i_ack), .o_grant_vec(g0_vec), .o_grant_idx(g0_idx), .o_grant_valid(g0_valid)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic int eff(input int p);
    int w;
    w = int'(i_weight[p*4 +: 4]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int find_from(input int start, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (start + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [3:0] vec, input logic [1:0] idx,
                     input logic valid, input int e);
    logic [3:0] ev;
    logic [1:0] ei;
    logic       evl;
    ev  = (e < 0) ? 4'b0000 : (4'b0001 << e);
    ei  = (e < 0) ? 2'd0 : 2'(e);
    evl = (e >= 0);
    checks++;
    assert ({vec, idx, valid} === {ev, ei, evl}) else begin
      errors++;
      $error("FAIL %s: vec=%b idx=%0d valid=%b, want vec=%b idx=%0d valid=%b",
             tag, vec, idx, valid, ev, ei, evl);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // driver: reset, checking that outputs are masked while reset is low
  task automatic do_reset();
    i_rstn    = 1'b0;
    i_req_vec = 4'b1111;
    i_ack     = 1'b1;
    #1;
    chk("reset_z1", g1_vec, g1_idx, g1_valid, -1);
    chk("reset_z0", g0_vec, g0_idx, g0_valid, -1);
    repeat (2) @(negedge i_clk);
    i_req_vec = 4'b0000;
    i_ack     = 1'b0;
    i_rstn    = 1'b1;
    for (int z = 0; z < 2; z++) begin
      m_own[z]  = -1;
      m_left[z] = 0;
      m_last[z] = 3;
      for (int p = 0; p < 4; p++) wait_beats[z][p] = 0;
    end
  endtask

  // driver: one cycle with directed expectations (-1 = no grant)
  task automatic cyc(input string tag, input logic [3:0] r, input logic a,
                     input int e1, input int e0);
    i_req_vec = r;
    i_ack     = a;
    #1;
    chk({tag, "_z1"}, g1_vec, g1_idx, g1_valid, e1);
    chk({tag, "_z0"}, g0_vec, g0_idx, g0_valid, e0);
    @(negedge i_clk);
  endtask

  // reference model: one cycle of ownership rules for mode z
  task automatic model_step(input int z, input logic [3:0] r, input logic a, output int g);
    int b;
    int nw;
    g = -1;
    if (m_own[z] >= 0 && r[m_own[z]]) begin
      g = m_own[z];
      if (a) begin
        m_left[z]--;
        if (m_left[z] == 0) begin
          m_last[z] = m_own[z];
          m_own[z]  = -1;
          if (z == 0) begin
            nw = find_from((m_last[z] + 1) % 4, r);
            if (nw >= 0) begin
              m_own[z]  = nw;
              m_left[z] = eff(nw);
            end
          end
        end
      end
    end else begin
      if (m_own[z] >= 0) begin
        m_last[z] = m_own[z];
        m_own[z]  = -1;
      end
      nw = find_from((m_last[z] + 1) % 4, r);
      if (z == 1) begin
        g = nw;
        if (nw >= 0) begin
          b = eff(nw);
          if (a) b--;
          if (b == 0) m_last[z] = nw;
          else begin
            m_own[z]  = nw;
            m_left[z] = b;
          end
        end
      end else if (nw >= 0) begin
        m_own[z]  = nw;
        m_left[z] = eff(nw);
      end
    end
  endtask

  initial begin
    int g;
    int obs;
    logic [3:0] r;
    logic [3:0] vec;
    logic [1:0] idx;
    logic       vld;
    int exp_z1[9];
    int exp_z0[9];
    i_weight = 16'h0000;

    // T1: all weights 2, everyone requests, ack every cycle
    do_reset();
    i_weight = 16'h2222;
    exp_z1 = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    exp_z0 = '{-1, 0, 0, 1, 1, 2, 2, 3, 3};
    for (int i = 0; i < 9; i++) cyc("equal_w2", 4'b1111, 1'b1, exp_z1[i], exp_z0[i]);

    // T2: weights {1,3,1,1}, ports 0/1 request
    do_reset();
    i_weight = 16'h1131;
    exp_z1 = '{0, 1, 1, 1, 0, 1, 1, 1, 0};
    exp_z0 = '{-1, 0, 1, 1, 1, 0, 1, 1, 1};
    for (int i = 0; i < 8; i++) cyc("w1311", 4'b0011, 1'b1, exp_z1[i], exp_z0[i]);

    // T3: port 2 (weight 5) drops after two acks, port 3 takes over
    do_reset();
    i_weight = 16'h2511;
    cyc("drop_a", 4'b0100, 1'b0, 2, -1);
    cyc("drop_b", 4'b0100, 1'b1, 2, 2);
    cyc("drop_c", 4'b0100, 1'b1, 2, 2);
    cyc("drop_d", 4'b1000, 1'b0, 3, -1);
    cyc("drop_e", 4'b1000, 1'b0, 3, 3);
    chk_int("last_after_drop_z1", int'(u_z1.last_q), 2);
    chk_int("last_after_drop_z0", int'(u_z0.last_q), 2);

    // T4: no acks for 20 cycles, weight change mid-ownership ignored
    do_reset();
    i_weight = 16'h0030;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) i_weight = 16'h9999;
      cyc("hold", 4'b0010, 1'b0, 1, (i == 0) ? -1 : 1);
    end
    chk_int("hold_credit_z1", int'(u_z1.credit_q), 3);
    chk_int("hold_credit_z0", int'(u_z0.credit_q), 3);

    // T5: weight 0 behaves as one beat per turn
    do_reset();
    i_weight = 16'h0000;
    exp_z1 = '{0, 1, 2, 3, 0, 1, 0, 0, 0};
    exp_z0 = '{-1, 0, 1, 2, 3, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) cyc("w0", 4'b1111, 1'b1, exp_z1[i], exp_z0[i]);

    // T6: reset while port 3 owns with credit 2
    do_reset();
    i_weight = 16'h3111;
    cyc("pre_rst_a", 4'b1000, 1'b0, 3, -1);
    cyc("pre_rst_b", 4'b1000, 1'b1, 3, 3);
    chk_int("pre_rst_credit_z1", int'(u_z1.credit_q), 2);
    i_rstn = 1'b0;
    #1;
    chk("mid_rst_z1", g1_vec, g1_idx, g1_valid, -1);
    chk("mid_rst_z0", g0_vec, g0_idx, g0_valid, -1);
    @(negedge i_clk);
    i_rstn = 1'b1;
    cyc("post_rst_a", 4'b1010, 1'b0, 1, -1);
    cyc("post_rst_b", 4'b1010, 1'b0, 1, 1);

    // T7: random traffic against the reference model, both modes
    do_reset();
    r = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < 4; p++) if ($urandom_range(0, 7) == 0) r[p] = ~r[p];
      if ($urandom_range(0, 15) == 0) i_weight = 16'($urandom);
      i_req_vec = r;
      i_ack     = ($urandom_range(0, 9) < 7);
      #1;
      for (int z = 0; z < 2; z++) begin
        vec = (z == 1) ? g1_vec : g0_vec;
        idx = (z == 1) ? g1_idx : g0_idx;
        vld = (z == 1) ? g1_valid : g0_valid;
        model_step(z, r, i_ack, g);
        chk((z == 1) ? "rand_z1" : "rand_z0", vec, idx, vld, g);
        checks++;
        assert ($onehot0(vec) && ((vec & ~r) == 4'b0000)) else begin
          errors++;
          $error("FAIL onehot_req_z%0d: vec=%b req=%b", z, vec, r);
        end
        obs = vld ? int'(idx) : -1;
        for (int p = 0; p < 4; p++) begin
          if (!r[p] || obs == p) wait_beats[z][p] = 0;
          else if (vld && i_ack) wait_beats[z][p]++;
          checks++;
          assert (wait_beats[z][p] <= 64) else begin
            errors++;
            $error("FAIL starve_z%0d_p%0d: waited %0d beats, want <= 64", z, p, wait_beats[z][p]);
          end
        end
      end
      @(negedge i_clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
